videoram_port_arbiter: RTL
==========================

Name: videoram_port_arbiter

Overview:
- Shares the single FPGA-side videoram port of the NIOS system between two requesters.
- The display scanout reader is read-only and has priority.
- The barcode overlay writer can read and write.
- Pipelined: one access per cycle, fixed read latency, starvation guard for the writer.
- Sits between the VGA/overlay logic and the system's videoram port (12-bit word address, 32-bit data, byte enables).

Parameters:
ADDR_W, 12, videoram word address width
DATA_W, 32, videoram data width; BE_W = DATA_W/8
MAX_STARVE, 8, max consecutive display grants while writer waits (1..255)

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
disp_req  in  1  display read request
disp_addr  in  ADDR_W  display read address
disp_ready  out  1  display request accepted this cycle (combinational)
disp_rdata  out  DATA_W  display read data
disp_rvalid  out  1  disp_rdata valid, one-cycle pulse
wr_req  in  1  writer request
wr_we  in  1  1 = write, 0 = read
wr_addr  in  ADDR_W  writer address
wr_wdata  in  DATA_W  writer write data
wr_be  in  BE_W  writer byte enables (writes only)
wr_ready  out  1  writer request accepted this cycle (combinational)
wr_rdata  out  DATA_W  writer read data
wr_rvalid  out  1  wr_rdata valid, one-cycle pulse (reads only)
videoram_address  out  ADDR_W  memory address
videoram_chipselect  out  1  memory select
videoram_clken  out  1  memory clock enable
videoram_write  out  1  memory write strobe
videoram_writedata  out  DATA_W  memory write data
videoram_byteenable  out  BE_W  memory byte enables
videoram_readdata  in  DATA_W  memory read data (1-cycle synchronous read)

Behaviour:
- Reset (async, active-low): every output 0, including videoram_clken. Starve counter 0, tag pipe empty.
- videoram_clken is registered. It becomes 1 at the first clk_clk edge after reset release and stays 1.
- Grant is combinational, evaluated each cycle. Order:
  (a) writer, if wr_req and starve_cnt == MAX_STARVE;
  (b) otherwise display, if disp_req;
  (c) otherwise writer, if wr_req;
  (d) otherwise none.
- disp_ready and wr_ready equal the grant. A transfer occurs when req && ready. A request may change or drop while not ready.
- starve_cnt:
  - +1, saturating at MAX_STARVE, in any cycle where wr_req is high and display is granted;
  - cleared when writer is granted or wr_req is low.
- Bus stage (registered, cycle N+1 for a handshake in cycle N):
  - chipselect = any grant;
  - write = writer granted && wr_we;
  - address = winner's address;
  - writedata = wr_wdata on writer write;
  - byteenable = wr_be for a write, all-ones for any read.
- No-grant cycle: chipselect=0, write=0, byteenable=0; address and writedata hold.
- Read return:
  - videoram_readdata is valid in cycle N+2;
  - it is captured into the owner's rdata register, with the owner's rvalid high, in cycle N+3;
  - fixed latency 3, in order, no bubbles; back-to-back reads from either side give back-to-back rvalids.
- rdata registers hold their last value while rvalid is low. The non-owner's rvalid stays 0.
- Writes produce no response. A writer read issued after a writer write to the same address returns the new data, because bus order equals grant order.
- Simultaneous requests: display wins unless the starve rule fires. Only one access per cycle.
- Reset mid-operation: in-flight tags are discarded. No rvalid is produced for any pre-reset handshake.

Decomposition:
- Package videoram_arb_pkg:
  - ADDR_W, DATA_W, BE_W defaults;
  - READ_LATENCY = 3;
  - owner enum {OWN_NONE, OWN_DISP, OWN_WR};
  - grant-select function.
- Sub-module videoram_rd_tag_pipe: 2-stage shift register of {read_valid, owner} that drives the rdata capture enables. Async active-low reset clears it.

Test Plan:
- Reset: hold reset_reset_n=0 with both requests high → all outputs 0, clken 0. Release → clken=1 after the first edge, first grant goes to display.
- Display read: memory word 0x123 = 0xDEADBEEF, disp_req with addr 0x123 for one cycle N → disp_rvalid=1 only in N+3 with 0xDEADBEEF, wr_rvalid stays 0.
- Byte-enable write: word 0x010 = 0x11223344, writer write 0xA5A5A5A5 with be=4'b0011, then writer read of 0x010 in the next cycle → wr_rdata 0x1122A5A5 at read handshake+3.
- Starvation: disp_req held high, wr_req raised at cycle T → display granted T..T+7, writer granted at T+8 (disp_ready=0 there), display resumes at T+9.
- Interleave: alternate display reads (0x000..0x003) and writer reads (0x100..0x103) at full rate → each rvalid carries its own address's data, no cross-routing, one access per cycle on the bus.
- Mid-flight reset: two reads accepted, reset asserted one cycle later → no rvalid before or after release, outputs 0 during reset.

Source files
------------

// File: rtl/videoram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : videoram_arb_pkg
// Description : Shared widths, read latency, owner encoding, read-tag type
//               and the grant priority function for the videoram arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package videoram_arb_pkg;

    localparam int DEF_ADDR_W   = 12;
    localparam int DEF_DATA_W   = 32;
    localparam int READ_LATENCY = 3;

    // Which requester owns an access (or a returning read word)
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_WR   = 2'd2
    } owner_e;

    // One in-flight read marker travelling alongside the memory access
    typedef struct packed {
        logic   rd_valid;
        owner_e owner;
    } rd_tag_t;

    // Priority: starved writer, then display, then writer, else nobody
    function automatic owner_e grant_select(
        input logic disp_req,
        input logic wr_req,
        input logic starved
    );
        owner_e sel;
        if (wr_req && starved) begin
            sel = OWN_WR;
        end else if (disp_req) begin
            sel = OWN_DISP;
        end else if (wr_req) begin
            sel = OWN_WR;
        end else begin
            sel = OWN_NONE;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/videoram_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : videoram_rd_tag_pipe
// Description : Shift register of read tags that lines up each accepted read
//               with the cycle its word appears on videoram_readdata.
// Revision    : 1.0 - initial release
// ============================================================================
module videoram_rd_tag_pipe
    import videoram_arb_pkg::*;
#(
    parameter int DEPTH = READ_LATENCY - 1
) (
    input  logic    clk_clk,
    input  logic    reset_reset_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t [DEPTH-1:0] r_stage;

    // Advance tags one stage per cycle; reset drops everything in flight
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign tag_out = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/videoram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : videoram_port_arbiter
// Description : Shares one videoram port between the display scanout reader
//               (priority, read-only) and the overlay writer (read/write),
//               one access per cycle, fixed 3-cycle read return, and a
//               starvation guard that forces a writer grant.
// Revision    : 1.0 - initial release
// ============================================================================
module videoram_port_arbiter
    import videoram_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BE_W       = DATA_W / 8,
    parameter int MAX_STARVE = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    // display scanout reader
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ready,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    // overlay writer
    input  logic              wr_req,
    input  logic              wr_we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_wdata,
    input  logic [BE_W-1:0]   wr_be,
    output logic              wr_ready,
    output logic [DATA_W-1:0] wr_rdata,
    output logic              wr_rvalid,
    // videoram port
    output logic [ADDR_W-1:0] videoram_address,
    output logic              videoram_chipselect,
    output logic              videoram_clken,
    output logic              videoram_write,
    output logic [DATA_W-1:0] videoram_writedata,
    output logic [BE_W-1:0]   videoram_byteenable,
    input  logic [DATA_W-1:0] videoram_readdata
);

    localparam logic [7:0] c_max_starve = 8'(MAX_STARVE);

    logic              r_clken;
    logic [7:0]        r_starve_cnt;
    owner_e            w_grant;
    logic              w_starved;
    logic              w_disp_go;
    logic              w_wr_go;
    rd_tag_t           w_tag_in;
    rd_tag_t           w_tag_out;

    logic              r_cs;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;

    logic [DATA_W-1:0] r_disp_rdata;
    logic [DATA_W-1:0] r_wr_rdata;
    logic              r_disp_rvalid;
    logic              r_wr_rvalid;

    // Clock enable rises on the first edge after reset and doubles as "running"
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_clken <= 1'b0;
        end else begin
            r_clken <= 1'b1;
        end
    end

    // Combinational grant; nothing is granted until the port is running
    always_comb begin
        w_starved = (r_starve_cnt == c_max_starve);
        w_grant   = OWN_NONE;
        if (r_clken) begin
            w_grant = grant_select(disp_req, wr_req, w_starved);
        end
    end

    assign disp_ready = (w_grant == OWN_DISP);
    assign wr_ready   = (w_grant == OWN_WR);
    assign w_disp_go  = disp_req && disp_ready;
    assign w_wr_go    = wr_req && wr_ready;

    // Build the read tag for this cycle's handshake (writes carry no tag)
    always_comb begin
        w_tag_in.rd_valid = w_disp_go || (w_wr_go && !wr_we);
        w_tag_in.owner    = OWN_NONE;
        if (w_disp_go) begin
            w_tag_in.owner = OWN_DISP;
        end else if (w_wr_go) begin
            w_tag_in.owner = OWN_WR;
        end
    end

    // Count display wins while the writer waits; saturate at the limit
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_starve_cnt <= 8'd0;
        end else if (!wr_req || w_wr_go) begin
            r_starve_cnt <= 8'd0;
        end else if (w_disp_go && (r_starve_cnt != c_max_starve)) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    // Bus stage: register the winning access; idle cycles keep address/data
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_cs    <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_disp_go) begin
            r_cs    <= 1'b1;
            r_write <= 1'b0;
            r_addr  <= disp_addr;
            r_be    <= '1;
        end else if (w_wr_go) begin
            r_cs    <= 1'b1;
            r_write <= wr_we;
            r_addr  <= wr_addr;
            if (wr_we) begin
                r_wdata <= wr_wdata;
                r_be    <= wr_be;
            end else begin
                r_be    <= '1;
            end
        end else begin
            r_cs    <= 1'b0;
            r_write <= 1'b0;
            r_be    <= '0;
        end
    end

    videoram_rd_tag_pipe #(
        .DEPTH (READ_LATENCY - 1)
    ) u_tag_pipe (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .tag_in        (w_tag_in),
        .tag_out       (w_tag_out)
    );

    // Route the returning word to its owner and pulse that owner's rvalid
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_disp_rdata  <= '0;
            r_wr_rdata    <= '0;
            r_disp_rvalid <= 1'b0;
            r_wr_rvalid   <= 1'b0;
        end else begin
            r_disp_rvalid <= w_tag_out.rd_valid && (w_tag_out.owner == OWN_DISP);
            r_wr_rvalid   <= w_tag_out.rd_valid && (w_tag_out.owner == OWN_WR);
            if (w_tag_out.rd_valid && (w_tag_out.owner == OWN_DISP)) begin
                r_disp_rdata <= videoram_readdata;
            end
            if (w_tag_out.rd_valid && (w_tag_out.owner == OWN_WR)) begin
                r_wr_rdata <= videoram_readdata;
            end
        end
    end

    assign videoram_clken      = r_clken;
    assign videoram_chipselect = r_cs;
    assign videoram_write      = r_write;
    assign videoram_address    = r_addr;
    assign videoram_writedata  = r_wdata;
    assign videoram_byteenable = r_be;
    assign disp_rdata          = r_disp_rdata;
    assign disp_rvalid         = r_disp_rvalid;
    assign wr_rdata            = r_wr_rdata;
    assign wr_rvalid           = r_wr_rvalid;

endmodule
`default_nettype wire
